// File: rtl/or_accum16.sv
// Packet OR accumulator: ORs every word of a packet and presents the result.
// Define OR_ACCUM_COUNT_EN to add the saturating out_count word counter.
module or_accum16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data
`ifdef OR_ACCUM_COUNT_EN
    ,
    output logic [15:0] out_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_d;
    logic [15:0] acc;
    logic [15:0] acc_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
        end else begin
            state <= state_d;
            acc   <= acc_d;
        end
    end

    // Handshake outputs depend on state alone, never on in_valid/out_ready.
    always_comb begin
        state_d   = state;
        acc_d     = acc;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d   = in_data;
                    state_d = in_last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d   = acc | in_data;
                    state_d = in_last ? DONE : ACCUM;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    acc_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                acc_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign out_data = acc;

`ifdef OR_ACCUM_COUNT_EN
    logic [15:0] cnt;
    logic [15:0] cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_d;
        end
    end

    // First word loads 1; later words count up and stick at 0xFFFF.
    always_comb begin
        cnt_d = cnt;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    cnt_d = 16'd1;
                end
            end
            ACCUM: begin
                if (in_valid && (cnt != 16'hFFFF)) begin
                    cnt_d = cnt + 16'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    cnt_d = '0;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    assign out_count = cnt;
`endif

endmodule

// File: tb/tb_or_accum16.sv
// Bench for or_accum16: directed vector table, then random traffic
// checked against a packet-level reference model.
module tb_or_accum16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
`ifdef OR_ACCUM_COUNT_EN
    logic [15:0] out_count;
`endif

    int checks = 0;
    int errors = 0;

    or_accum16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef OR_ACCUM_COUNT_EN
        ,
        .out_count (out_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst_n;
        logic        iv;
        logic [15:0] d;
        logic        last;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [15:0] e_d;
        logic [15:0] e_c;
    } vec_t;

    vec_t tv[$];

    function automatic void add(string nm, logic r, logic iv,
                                logic [15:0] d, logic l, logic o,
                                logic eir, logic eov,
                                logic [15:0] ed, logic [15:0] ec);
        vec_t v;
        v.name = nm; v.rst_n = r; v.iv = iv; v.d = d;
        v.last = l; v.ordy = o; v.e_ir = eir; v.e_ov = eov;
        v.e_d = ed; v.e_c = ec;
        tv.push_back(v);
    endfunction

    task automatic chk(string nm, logic eir, logic eov,
                       logic [15:0] ed, logic [15:0] ec);
        logic        ok;
        logic [15:0] ac;
        ac = 16'h0;
        ok = (in_ready === eir) && (out_valid === eov) &&
             (out_data === ed);
`ifdef OR_ACCUM_COUNT_EN
        ac = out_count;
        ok = ok && (out_count === ec);
`endif
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got ir=%b ov=%b d=%h c=%h, want ir=%b ov=%b d=%h c=%h",
                     nm, in_ready, out_valid, out_data, ac,
                     eir, eov, ed, ec);
        end
    endtask

    task automatic drive(logic r, logic iv, logic [15:0] d,
                         logic l, logic o);
        rst_n     = r;
        in_valid  = iv;
        in_data   = d;
        in_last   = l;
        out_ready = o;
    endtask

    // Reference model: words of the current packet and a result-pending flag.
    logic [15:0] words[$];
    logic        done;

    function automatic logic [15:0] or_all();
        logic [15:0] r;
        r = 16'h0;
        foreach (words[i]) r |= words[i];
        return r;
    endfunction

    function automatic logic [15:0] cnt_all();
        return (words.size() > 65535) ? 16'hFFFF : 16'(words.size());
    endfunction

    initial begin
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);

        add("reset",        0,0,16'h0000,0,0, 1,0,16'h0000,0);
        add("one_word",     1,1,16'hA5A5,1,0, 0,1,16'hA5A5,1);
        add("one_word_out", 1,0,16'h0000,0,1, 1,0,16'h0000,0);
        add("two_w1",       1,1,16'hA5A5,0,1, 1,0,16'hA5A5,1);
        add("two_w2",       1,1,16'h5A5A,1,1, 0,1,16'hFFFF,2);
        add("two_idle",     1,0,16'h0000,0,1, 1,0,16'h0000,0);
        add("gap_w1",       1,1,16'h0001,0,1, 1,0,16'h0001,1);
        add("gap_hold1",    1,0,16'hFFFF,0,1, 1,0,16'h0001,1);
        add("gap_hold2",    1,0,16'hFFFF,1,1, 1,0,16'h0001,1);
        add("gap_w2",       1,1,16'h0100,1,0, 0,1,16'h0101,2);
        add("gap_out",      1,0,16'h0000,0,1, 1,0,16'h0000,0);
        add("zero_word",    1,1,16'h0000,1,0, 0,1,16'h0000,1);
        add("zero_stall1",  1,0,16'h0000,0,0, 0,1,16'h0000,1);
        add("zero_stall2",  1,1,16'h1234,1,0, 0,1,16'h0000,1);
        add("zero_stall3",  1,0,16'h0000,0,0, 0,1,16'h0000,1);
        add("zero_out",     1,0,16'h0000,0,1, 1,0,16'h0000,0);
        add("rst_w1",       1,1,16'h0F00,0,1, 1,0,16'h0F00,1);
        add("rst_prio",     0,1,16'h1234,1,1, 1,0,16'h0000,0);
        add("rst_w2",       1,1,16'h0003,1,0, 0,1,16'h0003,1);
        add("rst_out",      1,0,16'h0000,0,1, 1,0,16'h0000,0);
        add("busy_w1",      1,1,16'hFFFF,1,0, 0,1,16'hFFFF,1);
        add("busy_hold",    1,1,16'hFFFF,1,0, 0,1,16'hFFFF,1);
        add("busy_out",     1,1,16'hFFFF,1,1, 1,0,16'h0000,0);
        add("busy_w2",      1,1,16'hFFFF,1,0, 0,1,16'hFFFF,1);
        add("busy_out2",    1,0,16'h0000,0,1, 1,0,16'h0000,0);
        add("done_w",       1,1,16'h00AA,1,0, 0,1,16'h00AA,1);
        add("done_rst",     0,0,16'h0000,0,0, 1,0,16'h0000,0);
        add("post_rst",     1,0,16'h0000,0,1, 1,0,16'h0000,0);

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].rst_n, tv[i].iv, tv[i].d, tv[i].last, tv[i].ordy);
            @(posedge clk);
            #1;
            chk(tv[i].name, tv[i].e_ir, tv[i].e_ov, tv[i].e_d, tv[i].e_c);
        end

        // Random traffic against the packet model, from a known reset.
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        words.delete();
        done = 1'b0;
        for (int n = 0; n < 600; n++) begin
            logic        r;
            logic        iv;
            logic [15:0] d;
            logic        l;
            logic        o;
            r  = ($urandom_range(0, 49) != 0);
            iv = ($urandom_range(0, 3) != 0);
            d  = 16'($urandom) & 16'($urandom);
            l  = ($urandom_range(0, 3) == 0);
            o  = ($urandom_range(0, 2) != 0);
            drive(r, iv, d, l, o);
            if (!r) begin
                words.delete();
                done = 1'b0;
            end else if (done) begin
                if (o) begin
                    words.delete();
                    done = 1'b0;
                end
            end else if (iv) begin
                words.push_back(d);
                if (l) done = 1'b1;
            end
            @(posedge clk);
            #1;
            chk("random", !done, done, or_all(), cnt_all());
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
